// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   ST_*        : FSM state encoding (IDLE -> SHIFT -> DONE -> IDLE)
//   BCD_DIG_W   : bits per packed BCD digit
//   ADD3_THRESH : digit value at or above which +3 is applied before a shift
//   digits_ok() : true when NDIG decimal digits can hold every BIN_W-bit value
package bcd_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int unsigned BCD_DIG_W   = 4;
  localparam logic [3:0]  ADD3_THRESH = 4'd5;

  // 2^bin_w - 1 <= 10^ndig - 1
  function automatic bit digits_ok(int unsigned bin_w, int unsigned ndig);
    longint unsigned max_bin;
    longint unsigned pow10;
    max_bin = (64'd1 << bin_w) - 64'd1;
    pow10   = 64'd1;
    for (int unsigned i = 0; i < ndig; i++) begin
      pow10 = pow10 * 64'd10;
    end
    return max_bin <= (pow10 - 64'd1);
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more so that the
// following left shift carries correctly into the next decimal digit.
//   d : 4-bit digit in
//   q : corrected digit out (d >= 5 ? d + 3 : d)
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [BCD_DIG_W-1:0] d,
  output logic [BCD_DIG_W-1:0] q
);

  always_comb begin
    q = d;
    if (d >= ADD3_THRESH) begin
      q = d + 4'd3;
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock (shift-and-add-3).
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   start : request conversion, sampled only in IDLE
//   bin   : binary operand, captured on the accept edge
//   busy  : high while a conversion is in flight (SHIFT or DONE)
//   done  : one-cycle pulse; bcd is valid from this cycle until the next completion
//   bcd   : packed digits, [3:0]=ones, [7:4]=tens, ...
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W = 7,
  parameter int unsigned NDIG  = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [BIN_W-1:0]          bin,
  output logic                      busy,
  output logic                      done,
  output logic [BCD_DIG_W*NDIG-1:0] bcd
);

  localparam int unsigned BCD_W = BCD_DIG_W * NDIG;
  localparam int unsigned CNT_W = $clog2(BIN_W) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  if (!digits_ok(BIN_W, NDIG)) begin : g_ndig_check
    $error("bin_to_bcd_seq: NDIG=%0d too small for BIN_W=%0d", NDIG, BIN_W);
  end

  logic [1:0]       state_q, state_d;
  logic [BIN_W-1:0] bin_sr_q, bin_sr_d;
  logic [BCD_W-1:0] dig_sr_q, dig_sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;

  logic [BCD_W-1:0] dig_adj;
  logic [BCD_W-1:0] dig_shift;
  logic [BIN_W-1:0] bin_shift;
  logic             unused_dig_msb;

  for (genvar g = 0; g < NDIG; g++) begin : g_add3
    bcd_add3 u_add3 (
      .d(dig_sr_q[g*BCD_DIG_W +: BCD_DIG_W]),
      .q(dig_adj[g*BCD_DIG_W +: BCD_DIG_W])
    );
  end

  // The corrected top bit always falls off the end: a valid top digit never reaches 8.
  assign dig_shift      = {dig_adj[BCD_W-2:0], bin_sr_q[BIN_W-1]};
  assign bin_shift      = {bin_sr_q[BIN_W-2:0], 1'b0};
  assign unused_dig_msb = dig_adj[BCD_W-1];

  always_comb begin
    state_d  = state_q;
    bin_sr_d = bin_sr_q;
    dig_sr_d = dig_sr_q;
    cnt_d    = cnt_q;
    bcd_d    = bcd_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          bin_sr_d = bin;
          dig_sr_d = '0;
          cnt_d    = '0;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        bin_sr_d = bin_shift;
        dig_sr_d = dig_shift;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          bcd_d   = dig_shift;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      bin_sr_q <= '0;
      dig_sr_q <= '0;
      cnt_q    <= '0;
      bcd_q    <= '0;
    end else begin
      state_q  <= state_d;
      bin_sr_q <= bin_sr_d;
      dig_sr_q <= dig_sr_d;
      cnt_q    <= cnt_d;
      bcd_q    <= bcd_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);
  assign bcd  = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        st [2];
  logic [9:0]  bv [2];
  logic        busy [2];
  logic        done [2];
  logic [11:0] bcd_a;
  logic [15:0] bcd_b;

  int checks = 0;
  int errors = 0;

  // model state per instance: cycles since accept (saturating), captured value, held result
  int m_since [2];
  int m_cap   [2];
  int m_bcd   [2];

  bin_to_bcd_seq #(.BIN_W(7), .NDIG(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .bin(bv[0][6:0]),
    .busy(busy[0]), .done(done[0]), .bcd(bcd_a)
  );

  bin_to_bcd_seq #(.BIN_W(10), .NDIG(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .bin(bv[1]),
    .busy(busy[1]), .done(done[1]), .bcd(bcd_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int w_of(int i);
    return (i == 0) ? 7 : 10;
  endfunction

  function automatic int to_bcd(int v);
    int r;
    int x;
    r = 0;
    x = v;
    for (int d = 0; d < 5; d++) begin
      r = r | ((x % 10) << (4 * d));
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int bcd_of(int i);
    return (i == 0) ? int'(bcd_a) : int'(bcd_b);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a conversion occupies W+1 cycles after the accept edge,
  // the result appears with DONE W edges after accept.
  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_since[i] <= 100;
        m_cap[i]   <= 0;
        m_bcd[i]   <= 0;
      end else if (m_since[i] >= w_of(i) + 1) begin
        if (st[i]) begin
          m_since[i] <= 0;
          m_cap[i]   <= int'(bv[i]) & ((1 << w_of(i)) - 1);
        end
      end else begin
        m_since[i] <= m_since[i] + 1;
        if (m_since[i] + 1 == w_of(i)) m_bcd[i] <= to_bcd(m_cap[i]);
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("busy[%0d]", i), int'(busy[i]), int'(m_since[i] < w_of(i) + 1));
      chk($sformatf("done[%0d]", i), int'(done[i]), int'(m_since[i] == w_of(i)));
      chk($sformatf("bcd[%0d]", i), bcd_of(i), m_bcd[i]);
    end
    for (int d = 0; d < 3; d++) begin
      if (dut_a.dig_sr_q[4*d +: 4] > 4'd9) chk("digit_range_a", int'(dut_a.dig_sr_q[4*d +: 4]), 9);
    end
    for (int d = 0; d < 4; d++) begin
      if (dut_b.dig_sr_q[4*d +: 4] > 4'd9) chk("digit_range_b", int'(dut_b.dig_sr_q[4*d +: 4]), 9);
    end
  end

  // One START pulse, then wait (bounded) for DONE and check the result.
  task automatic conv(input int i, input int v, input int exp_bcd);
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    st[i] = 1'b1;
    bv[i] = 10'(v);
    @(negedge clk);
    st[i] = 1'b0;
    for (int n = 0; n < 30 && !seen; n++) begin
      if (done[i]) seen = 1'b1;
      else @(negedge clk);
    end
    chk($sformatf("conv_done[%0d] v=%0d", i, v), int'(seen), 1);
    chk($sformatf("conv_bcd[%0d] v=%0d", i, v), bcd_of(i), exp_bcd);
  endtask

  initial begin
    int n;
    int cnt;
    st[0] = 1'b0; st[1] = 1'b0; bv[0] = '0; bv[1] = '0;
    rst_n = 1'b0;

    // pin the reference function
    chk("model_127", to_bcd(127), 'h127);
    chk("model_0", to_bcd(0), 'h0);
    chk("model_505", to_bcd(505), 'h505);
    chk("model_1023", to_bcd(1023), 'h1023);

    repeat (2) @(negedge clk);
    chk("reset_busy", int'(busy[0]), 0);
    chk("reset_done", int'(done[0]), 0);
    chk("reset_bcd", int'(bcd_a), 0);
    rst_n = 1'b1;

    // 1) 127: DONE seven edges after accept, busy drops the cycle after
    @(negedge clk);
    st[0] = 1'b1; bv[0] = 10'd127;
    n = 0;
    for (int k = 1; k <= 20 && n == 0; k++) begin
      @(negedge clk);
      st[0] = 1'b0;
      if (done[0]) n = k;
    end
    chk("t1_latency", n, 8);
    chk("t1_bcd", int'(bcd_a), 'h127);
    @(negedge clk);
    chk("t1_busy_low", int'(busy[0]), 0);
    chk("t1_done_low", int'(done[0]), 0);

    // 2) edge values
    conv(0, 0, 'h000);
    conv(0, 9, 'h009);
    conv(0, 10, 'h010);
    conv(0, 99, 'h099);
    conv(0, 100, 'h100);

    // 3) START during SHIFT is ignored
    @(negedge clk);
    st[0] = 1'b1; bv[0] = 10'd64;
    @(negedge clk);
    st[0] = 1'b0;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (k == 2) begin st[0] = 1'b1; bv[0] = 10'd5; end
      if (k == 3) st[0] = 1'b0;
      if (done[0]) cnt++;
      @(negedge clk);
    end
    chk("t3_one_done", cnt, 1);
    chk("t3_bcd", int'(bcd_a), 'h064);

    // 4) START held, BIN stepping: one result per 9 cycles
    st[0] = 1'b1; bv[0] = 10'd0;
    cnt = 0;
    for (int k = 0; k < 180; k++) begin
      @(negedge clk);
      bv[0] = 10'((int'(bv[0]) + 1) % 128);
      if (done[0]) cnt++;
    end
    st[0] = 1'b0;
    chk("t4_done_count", cnt, 20);
    repeat (12) @(negedge clk);

    // 5) reset mid-conversion
    st[0] = 1'b1; bv[0] = 10'd127;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_busy", int'(busy[0]), 0);
    chk("t5_done", int'(done[0]), 0);
    chk("t5_bcd", int'(bcd_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    conv(0, 42, 'h042);

    // randomized traffic on both instances
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      st[0] = 1'($urandom_range(0, 3) == 0);
      st[1] = 1'($urandom_range(0, 3) == 0);
      bv[0] = 10'($urandom_range(0, 127));
      bv[1] = 10'($urandom_range(0, 1023));
    end
    st[0] = 1'b0; st[1] = 1'b0;
    repeat (15) @(negedge clk);

    // 6) exhaustive sweeps
    fork
      for (int v = 0; v < 128; v++) conv(0, v, ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
      for (int v = 0; v < 1024; v++) conv(1, v, to_bcd(v));
    join
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, errors %0d", errors);
    $fatal(1, "timeout");
  end

endmodule
